// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic FIR: widths, LUT geometry and the
// coefficient-load FSM encoding used by both the LUT generator and the filter controller.
package da_pkg;

  localparam int unsigned COEF_W    = 16;
  localparam int unsigned NTAPS     = 4;
  localparam int unsigned LUT_DEPTH = 16;
  localparam int unsigned LUT_W     = COEF_W + 2;
  localparam int unsigned ADDR_W    = $clog2(LUT_DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StGen     = 2'd2,
    StDone    = 2'd3
  } da_state_e;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [LUT_W-1:0]  lut_t;

endpackage

// File: rtl/da_lut_sum.sv
// Combinational masked adder: sums the coefficients whose mask bit is set, sign-extended
// to the LUT entry width.
module da_lut_sum #(
  parameter int unsigned COEF_W = 16,
  parameter int unsigned LUT_W  = COEF_W + 2
) (
  input  logic signed [COEF_W-1:0] c0,
  input  logic signed [COEF_W-1:0] c1,
  input  logic signed [COEF_W-1:0] c2,
  input  logic signed [COEF_W-1:0] c3,
  input  logic        [3:0]        mask,
  output logic signed [LUT_W-1:0]  sum
);

  localparam int unsigned ExtW = LUT_W - COEF_W;

  logic signed [LUT_W-1:0] t0, t1, t2, t3;

  always_comb begin
    t0 = mask[0] ? {{ExtW{c0[COEF_W-1]}}, c0} : '0;
    t1 = mask[1] ? {{ExtW{c1[COEF_W-1]}}, c1} : '0;
    t2 = mask[2] ? {{ExtW{c2[COEF_W-1]}}, c2} : '0;
    t3 = mask[3] ? {{ExtW{c3[COEF_W-1]}}, c3} : '0;
    sum = t0 + t1 + t2 + t3;
  end

endmodule

// File: rtl/da_lut_gen.sv
// Coefficient-load producer for the DA FIR: collects four taps, then streams the 16
// partial-sum ROM entries with a valid/ready handshake while cload is held high.
module da_lut_gen #(
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NTAPS  = 4,
  parameter int unsigned LUT_W  = COEF_W + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  output logic signed [LUT_W-1:0]  lut_data,
  output logic        [3:0]        lut_addr,
  output logic                     lut_valid,
  input  logic                     lut_ready,
  output logic                     cload,
  output logic                     done
);

  import da_pkg::*;

  if (NTAPS != 4) begin : g_ntaps_check
    $error("da_lut_gen supports exactly 4 taps per DA group");
  end

  da_state_e               state;
  logic        [1:0]       tap_cnt;
  logic signed [COEF_W-1:0] coef [4];
  logic        [3:0]       next_addr;
  logic signed [LUT_W-1:0] next_sum;

  assign next_addr = lut_addr + 4'd1;

  // Sum for the entry that follows the one currently presented.
  da_lut_sum #(
    .COEF_W (COEF_W),
    .LUT_W  (LUT_W)
  ) u_sum (
    .c0   (coef[0]),
    .c1   (coef[1]),
    .c2   (coef[2]),
    .c3   (coef[3]),
    .mask (next_addr),
    .sum  (next_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      tap_cnt    <= 2'd0;
      for (int i = 0; i < 4; i++) coef[i] <= '0;
      coef_ready <= 1'b1;
      lut_data   <= '0;
      lut_addr   <= 4'd0;
      lut_valid  <= 1'b0;
      cload      <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (coef_valid) begin
            coef[0] <= coef_in;
            tap_cnt <= 2'd1;
            state   <= StCollect;
          end
        end
        StCollect: begin
          if (coef_valid) begin
            coef[tap_cnt] <= coef_in;
            tap_cnt       <= tap_cnt + 2'd1;
            // Last tap: entry 0 (empty mask, sum 0) goes out on the same edge.
            if (tap_cnt == 2'd3) begin
              state      <= StGen;
              coef_ready <= 1'b0;
              lut_valid  <= 1'b1;
              cload      <= 1'b1;
              lut_addr   <= 4'd0;
              lut_data   <= '0;
            end
          end
        end
        StGen: begin
          if (lut_ready) begin
            if (lut_addr == 4'hF) begin
              state     <= StDone;
              lut_valid <= 1'b0;
              cload     <= 1'b0;
              done      <= 1'b1;
              lut_addr  <= 4'd0;
              lut_data  <= '0;
            end else begin
              lut_addr <= next_addr;
              lut_data <= next_sum;
            end
          end
        end
        StDone: begin
          done       <= 1'b0;
          coef_ready <= 1'b1;
          state      <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_lut_gen.sv
// Randomised and directed bench for da_lut_gen against an arithmetic model of the
// 16-entry partial-sum table.
module tb_da_lut_gen;

  localparam int unsigned COEF_W = 16;
  localparam int unsigned LUT_W  = COEF_W + 2;

  logic                     clk;
  logic                     reset;
  logic signed [COEF_W-1:0] coef_in;
  logic                     coef_valid;
  logic                     coef_ready;
  logic signed [LUT_W-1:0]  lut_data;
  logic        [3:0]        lut_addr;
  logic                     lut_valid;
  logic                     lut_ready;
  logic                     cload;
  logic                     done;

  da_lut_gen #(
    .COEF_W (COEF_W),
    .NTAPS  (4),
    .LUT_W  (LUT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .lut_data   (lut_data),
    .lut_addr   (lut_addr),
    .lut_valid  (lut_valid),
    .lut_ready  (lut_ready),
    .cload      (cload),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cs      [4];
  int exp_lut [16];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Entry a is the sum of the taps selected by the set bits of a.
  task automatic build_model();
    for (int a = 0; a < 16; a++) begin
      exp_lut[a] = 0;
      for (int j = 0; j < 4; j++) if (((a >> j) & 1) == 1) exp_lut[a] += cs[j];
    end
  endtask

  // Ends at the negedge right after the 4th tap is accepted.
  task automatic load_coefs(input int gap, input bit keep_valid);
    for (int i = 0; i < 4; i++) begin
      coef_in    = cs[i][COEF_W-1:0];
      coef_valid = 1'b1;
      check_eq("coef_ready_load", int'(coef_ready), 1);
      @(posedge clk);
      @(negedge clk);
      coef_valid = (i == 3) && keep_valid;
      if (i < 3) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic stream(input int stall_addr, input int stall_n, input bit garbage,
                        input int abort_addr);
    int cl_cycles = 0;
    for (int a = 0; a < 16; a++) begin
      if (garbage) coef_in = COEF_W'($urandom);
      if (a == abort_addr) begin
        #2 reset = 1'b1;
        #1;
        check_eq("rst_lut_valid", int'(lut_valid), 0);
        check_eq("rst_cload", int'(cload), 0);
        check_eq("rst_lut_addr", int'(lut_addr), 0);
        check_eq("rst_coef_ready", int'(coef_ready), 1);
        check_eq("rst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      check_eq("lut_valid", int'(lut_valid), 1);
      check_eq("lut_addr", int'(lut_addr), a);
      check_eq("lut_data", int'(lut_data), exp_lut[a]);
      check_eq("gen_coef_ready", int'(coef_ready), 0);
      check_eq("gen_done", int'(done), 0);
      if (cload) cl_cycles++;
      if (a == stall_addr) begin
        for (int s = 0; s < stall_n; s++) begin
          lut_ready = 1'b0;
          @(posedge clk);
          @(negedge clk);
          check_eq("stall_addr", int'(lut_addr), a);
          check_eq("stall_data", int'(lut_data), exp_lut[a]);
          check_eq("stall_valid", int'(lut_valid), 1);
          if (cload) cl_cycles++;
        end
        lut_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("cload_cycles", cl_cycles, 16 + ((stall_addr >= 0) ? stall_n : 0));
    check_eq("done_pulse", int'(done), 1);
    check_eq("done_lut_valid", int'(lut_valid), 0);
    check_eq("done_cload", int'(cload), 0);
    check_eq("done_lut_addr", int'(lut_addr), 0);
    check_eq("done_coef_ready", int'(coef_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("post_done", int'(done), 0);
    check_eq("post_coef_ready", int'(coef_ready), 1);
    check_eq("post_lut_valid", int'(lut_valid), 0);
    coef_valid = 1'b0;
  endtask

  task automatic run_case(input int gap, input int stall_addr, input int stall_n,
                          input bit garbage, input int abort_addr);
    build_model();
    load_coefs(gap, garbage);
    stream(stall_addr, stall_n, garbage, abort_addr);
  endtask

  initial begin
    logic signed [COEF_W-1:0] r;
    reset      = 1'b1;
    coef_in    = '0;
    coef_valid = 1'b0;
    lut_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_coef_ready", int'(coef_ready), 1);
    check_eq("reset_lut_valid", int'(lut_valid), 0);
    check_eq("reset_cload", int'(cload), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_lut_addr", int'(lut_addr), 0);
    check_eq("reset_lut_data", int'(lut_data), 0);
    reset = 1'b0;
    @(negedge clk);

    cs = '{3, -5, 7, 1};
    run_case(0, -1, 0, 1'b0, -1);
    cs = '{-32768, -32768, -32768, -32768};
    run_case(0, -1, 0, 1'b0, -1);
    cs = '{32767, 32767, 32767, 32767};
    run_case(0, -1, 0, 1'b0, -1);
    cs = '{3, -5, 7, 1};
    run_case(0, 7, 3, 1'b0, -1);
    run_case(2, -1, 0, 1'b0, -1);
    run_case(0, -1, 0, 1'b1, -1);
    run_case(0, -1, 0, 1'b0, 9);
    cs = '{-1234, 4321, 0, -7};
    run_case(0, -1, 0, 1'b0, -1);

    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        r = COEF_W'($urandom);
        cs[j] = r;
      end
      run_case(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
